shift_add_datapath: RTL
=======================

# shift_add_datapath

Sequential signed shift-and-add multiplier datapath. It takes two WIDTH-bit two's-complement operands and produces the 2·WIDTH-bit product in WIDTH add/shift steps. It is the arithmetic stage driven by the multiplier's step-sequencing control. It sits directly downstream of the step counter and has its own start/busy/done handshake toward the system.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal values are 4 to 16.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiplication. Sampled only in IDLE or DONE.
- `multiplicand`  in  WIDTH: signed operand M. Captured on the edge that accepts `start`.
- `multiplier`  in  WIDTH: signed operand Q. Captured on the edge that accepts `start`.
- `busy`  out  1: high while steps are in progress.
- `done`  out  1: one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  2·WIDTH: signed result. Held until the next accepted `start`.
- `step`  out  4: current step index, 0..WIDTH-1. Reads 0 outside RUN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when `start` is high.
  - RUN → DONE after step WIDTH-1.
  - DONE → RUN when `start` is high; otherwise DONE → IDLE.
- Registers:
  - A: accumulator, WIDTH+1 bits, sign-extended.
  - Qr: multiplier shift register, WIDTH bits.
  - Mr: multiplicand, WIDTH bits, sign-extended to WIDTH+1 for arithmetic.
- On accept: A←0, Qr←multiplier, Mr←multiplicand, step←0.
- Each RUN cycle, at step index i:
  - If Qr[0]=1 and i<WIDTH-1: A'←A+Mr.
  - If Qr[0]=1 and i=WIDTH-1: A'←A−Mr. This is the sign-bit weight correction.
  - If Qr[0]=0: A'←A.
  - Then arithmetic-shift {A',Qr} right by 1. A[WIDTH] replicates into itself.
  - step increments by 1.
- Arithmetic is WIDTH+1 bits and modulo 2^(WIDTH+1). The extra bit makes overflow impossible for any operand pair, including (−2^(WIDTH-1))².
- Result: product←{A[WIDTH-1:0], Qr} after the final shift. It is registered on the RUN→DONE edge.
- `start` while in RUN is ignored. Operands may change freely after capture.
- `start` held high continuously produces back-to-back multiplications with no IDLE cycle between them.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, product=0, step=0.
  - A, Qr and Mr are all 0.
- Reset has priority over everything. Asserted mid-RUN, it aborts the operation on that edge and no `done` is produced.
- Latency: let edge E0 accept `start`.
  - busy is high in the cycles after E0 through E_WIDTH.
  - Steps execute on edges E1..E_WIDTH.
  - After E_WIDTH: done=1, busy=0 and product is valid, so done is visible WIDTH cycles after the accepting edge.
  - `done` is high for exactly one cycle.
- Throughput: one result every WIDTH+1 cycles when `start` is held high.
- busy and done are never high together.

## Structure
- Package `mul_pkg`:
  - state enum `mul_state_t` {IDLE, RUN, DONE}.
  - `MUL_WIDTH_DEFAULT`=8.
  - `STEP_W`=4.
- Sub-module `mul_addsub`: (WIDTH+1)-bit adder/subtractor.
  - Inputs: a, b, sub.
  - Output: sum = sub ? a−b : a+b.
  - Purely combinational. Instantiated once for the A update.
- The FSM, step counter and shift registers stay in the top module.

## Test plan
- WIDTH=8, M=3, Q=5, start pulsed for 1 cycle → done exactly 8 cycles after the accepting edge; product=0x000F; busy high for 8 cycles; step reads 0..7.
- M=5, Q=−3 (0xFD) → product=0xFFF1 (−15). M=−128, Q=−128 → product=0x4000 (+16384). M=127, Q=−128 → product=0xC080 (−16256).
- M=0 or Q=0 → product=0x0000. A previous nonzero product is held until that point and then replaced.
- `start` held high with operand pairs (2,3) then (−4,6) → done pulses one cycle apart from RUN re-entry with no IDLE; products 0x0006 then 0xFFE8.
- `start` re-pulsed in mid-RUN with different operands → ignored; the original product is delivered.
- `rst` asserted at step 4 → next cycle busy=0, done=0, product=0, step=0, state=IDLE. A subsequent start with M=7, Q=7 → product=0x0031.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential signed shift-and-add multiplier.
package mul_pkg;

   // Control states of the multiplier datapath
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam int MUL_WIDTH_DEFAULT = 8;
   localparam int STEP_W            = 4;

endpackage : mul_pkg

// File: rtl/mul_addsub.sv
// Combinational adder/subtractor used for the accumulator update.
module mul_addsub #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   // Wraps modulo 2^W; the caller sizes W so that no overflow can occur
   assign sum = sub ? (a - b) : (a + b);

endmodule : mul_addsub

// File: rtl/shift_add_datapath.sv
// Sequential signed shift-and-add multiplier: WIDTH add/shift steps per product,
// with a start/busy/done handshake and a held product register.
module shift_add_datapath
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [STEP_W-1:0]    step
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

   mul_state_t           state_reg;
   logic [WIDTH:0]       a_reg;        // accumulator, one guard bit above WIDTH
   logic [WIDTH-1:0]     qr_reg;       // multiplier shift register
   logic [WIDTH-1:0]     mr_reg;       // captured multiplicand
   logic [STEP_W-1:0]    step_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [2*WIDTH-1:0]   product_reg;

   logic [WIDTH:0]       mr_ext;
   logic                 is_last;
   logic [WIDTH:0]       addsub_sum;
   logic [WIDTH:0]       a_sum;
   logic [WIDTH:0]       a_next;
   logic [WIDTH-1:0]     qr_next;

   assign mr_ext  = {mr_reg[WIDTH-1], mr_reg};
   assign is_last = (step_reg == LAST_STEP);

   // The last step subtracts: the multiplier's MSB carries negative weight
   mul_addsub #(
      .W   (WIDTH + 1)
   ) u_addsub (
      .a   (a_reg),
      .b   (mr_ext),
      .sub (is_last),
      .sum (addsub_sum)
   );

   // Select the accumulator update, then arithmetic-shift {A, Qr} right by one
   always_comb begin
      a_sum   = qr_reg[0] ? addsub_sum : a_reg;
      a_next  = {a_sum[WIDTH], a_sum[WIDTH:1]};
      qr_next = {a_sum[0], qr_reg[WIDTH-1:1]};
   end

   // Control FSM, step counter, shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         a_reg       <= '0;
         qr_reg      <= '0;
         mr_reg      <= '0;
         step_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         product_reg <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg <= RUN;
                  a_reg     <= '0;
                  qr_reg    <= multiplier;
                  mr_reg    <= multiplicand;
                  step_reg  <= '0;
                  busy_reg  <= 1'b1;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               a_reg  <= a_next;
               qr_reg <= qr_next;
               if (is_last) begin
                  state_reg   <= DONE;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  step_reg    <= '0;
                  product_reg <= {a_next[WIDTH-1:0], qr_next};
               end else begin
                  step_reg <= step_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               step_reg  <= '0;
            end
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = product_reg;
   assign step    = step_reg;

endmodule : shift_add_datapath
